// File: rtl/stage_pkg.sv
// Shared definitions for the stage sequencer: FSM state type, default
// parameter values and a width helper used to size address/index ports.
package stage_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PLAY,
      DONE
   } state_t;

   localparam int unsigned DEF_NUM_LEVELS    = 4;
   localparam int unsigned DEF_OBJECTS_COUNT = 20;
   localparam int unsigned DEF_FIELDS        = 3;
   localparam int unsigned DEF_DATA_W        = 9;
   localparam int unsigned DEF_TIME_LIMIT    = 60;
   localparam int unsigned DEF_TIME_W        = 9;
   localparam int unsigned DEF_MONEY_W       = 16;
   localparam int unsigned DEF_GOAL_BASE     = 100;
   localparam int unsigned DEF_GOAL_STEP     = 50;

   // Bits needed to index n items; never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/level_loader.sv
// Streams one level's object table out of a synchronous ROM: issues WORDS
// consecutive addresses from i_base, then mirrors each as a write one cycle later.
module level_loader
   import stage_pkg::*;
#(
   parameter int unsigned WORDS  = 60,
   parameter int unsigned ROM_AW = 8,
   parameter int unsigned IDX_W  = 6
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              i_start,
   input  logic [ROM_AW-1:0] i_base,
   output logic              o_busy,
   output logic              o_done,
   output logic [ROM_AW-1:0] o_rom_addr,
   output logic              o_wr_en,
   output logic [IDX_W-1:0]  o_wr_idx
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   logic              r_addr_busy;
   logic [IDX_W-1:0]  r_cnt;
   logic [ROM_AW-1:0] r_addr;
   logic              r_wr_en;
   logic [IDX_W-1:0]  r_wr_idx;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register sees the pre-edge value of every other register.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_addr_busy <= 1'b0;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_wr_en     <= 1'b0;
         r_wr_idx    <= '0;
      end else begin
         // The write for address k lands when the ROM presents its data.
         r_wr_en <= r_addr_busy;
         if (r_addr_busy) begin
            r_wr_idx <= r_cnt;
         end

         if (i_start) begin
            r_addr_busy <= 1'b1;
            r_cnt       <= '0;
            r_addr      <= i_base;
         end else if (r_addr_busy) begin
            if (r_cnt == LAST_IDX) begin
               r_addr_busy <= 1'b0;
            end else begin
               r_cnt  <= r_cnt + 1'b1;
               r_addr <= r_addr + 1'b1;
            end
         end
      end
   end

   assign o_busy     = r_addr_busy | r_wr_en;
   assign o_done     = r_wr_en && (r_wr_idx == LAST_IDX);
   assign o_rom_addr = r_addr_busy ? r_addr : '0;
   assign o_wr_en    = r_wr_en;
   assign o_wr_idx   = r_wr_en ? r_wr_idx : '0;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-level game sequencer: loads each level's objects from ROM, runs the
// per-level countdown, accumulates money and grades the level against its goal.
module stage_sequencer
   import stage_pkg::*;
#(
   parameter int unsigned NUM_LEVELS    = DEF_NUM_LEVELS,
   parameter int unsigned OBJECTS_COUNT = DEF_OBJECTS_COUNT,
   parameter int unsigned FIELDS        = DEF_FIELDS,
   parameter int unsigned DATA_W        = DEF_DATA_W,
   parameter int unsigned TIME_LIMIT    = DEF_TIME_LIMIT,
   parameter int unsigned TIME_W        = DEF_TIME_W,
   parameter int unsigned MONEY_W       = DEF_MONEY_W,
   parameter int unsigned GOAL_BASE     = DEF_GOAL_BASE,
   parameter int unsigned GOAL_STEP     = DEF_GOAL_STEP
) (
   input  logic                                                  clk,
   input  logic                                                  resetN,
   input  logic                                                  enable,
   input  logic                                                  oneSecPulse,
   input  logic                                                  collectValid,
   input  logic [MONEY_W-1:0]                                    collectValue,
   output logic [width_of(NUM_LEVELS*OBJECTS_COUNT*FIELDS)-1:0]  romAddr,
   input  logic [DATA_W-1:0]                                     romData,
   output logic                                                  objWrEn,
   output logic [width_of(OBJECTS_COUNT*FIELDS)-1:0]             objWrIdx,
   output logic [DATA_W-1:0]                                     objWrData,
   output logic                                                  loading,
   output logic                                                  playing,
   output logic [width_of(NUM_LEVELS)-1:0]                       currentLevel,
   output logic [TIME_W-1:0]                                     timeLeft,
   output logic [MONEY_W-1:0]                                    money,
   output logic                                                  stageEnded,
   output logic                                                  stageFailed,
   output logic                                                  lastLevelEnded
);

   localparam int unsigned WORDS  = OBJECTS_COUNT * FIELDS;
   localparam int unsigned ROM_AW = width_of(NUM_LEVELS * WORDS);
   localparam int unsigned IDX_W  = width_of(WORDS);
   localparam int unsigned LVL_W  = width_of(NUM_LEVELS);

   localparam logic [LVL_W-1:0]  LAST_LEVEL = LVL_W'(NUM_LEVELS - 1);
   localparam logic [TIME_W-1:0] TIME_INIT  = TIME_W'(TIME_LIMIT);

   state_t             r_state;
   state_t             w_next_state;
   logic               r_enable_d;
   logic [LVL_W-1:0]   r_level;
   logic [TIME_W-1:0]  r_time;
   logic [MONEY_W-1:0] r_money;
   logic [MONEY_W-1:0] r_lvl_money;
   logic               r_last;

   logic               w_enable_rise;
   logic               w_load_start;
   logic               w_load_busy;
   logic               w_load_done;
   logic               w_active;
   logic               w_tick;
   logic               w_expire;
   logic               w_collect;
   logic               w_pass;
   logic [MONEY_W-1:0] w_goal;
   logic [MONEY_W:0]   w_money_sum;
   logic [MONEY_W:0]   w_lvl_sum;
   logic [MONEY_W-1:0] w_money_sat;
   logic [MONEY_W-1:0] w_lvl_sat;
   logic [ROM_AW-1:0]  w_rom_base;
   logic               w_wr_en;
   logic [IDX_W-1:0]   w_wr_idx;
   logic [ROM_AW-1:0]  w_rom_addr;

   assign w_enable_rise = enable & ~r_enable_d;
   assign w_active      = (r_state == PLAY) && enable;
   assign w_tick        = w_active && oneSecPulse;
   assign w_expire      = w_tick && (r_time == TIME_W'(1));
   assign w_collect     = w_active && collectValid;

   // Both accumulators clamp at all-ones instead of wrapping.
   assign w_money_sum = {1'b0, r_money} + {1'b0, collectValue};
   assign w_lvl_sum   = {1'b0, r_lvl_money} + {1'b0, collectValue};
   assign w_money_sat = w_money_sum[MONEY_W] ? '1 : w_money_sum[MONEY_W-1:0];
   assign w_lvl_sat   = w_lvl_sum[MONEY_W] ? '1 : w_lvl_sum[MONEY_W-1:0];

   assign w_goal     = MONEY_W'(GOAL_BASE) + MONEY_W'(r_level) * MONEY_W'(GOAL_STEP);
   assign w_pass     = (r_lvl_money >= w_goal);
   assign w_rom_base = ROM_AW'(r_level) * ROM_AW'(WORDS);

   level_loader #(
      .WORDS  (WORDS),
      .ROM_AW (ROM_AW),
      .IDX_W  (IDX_W)
   ) u_loader (
      .clk        (clk),
      .resetN     (resetN),
      .i_start    (w_load_start),
      .i_base     (w_rom_base),
      .o_busy     (w_load_busy),
      .o_done     (w_load_done),
      .o_rom_addr (w_rom_addr),
      .o_wr_en    (w_wr_en),
      .o_wr_idx   (w_wr_idx)
   );

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and infers a latch.
      w_next_state = r_state;
      w_load_start = 1'b0;
      stageEnded   = 1'b0;
      stageFailed  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_enable_rise && !r_last) begin
               w_next_state = LOAD;
               w_load_start = 1'b1;
            end
         end
         LOAD: begin
            if (w_load_done) begin
               w_next_state = PLAY;
            end
         end
         PLAY: begin
            if (w_expire) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            stageEnded   = w_pass;
            stageFailed  = !w_pass;
            w_next_state = IDLE;
         end
         default: w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_enable_d  <= 1'b0;
         r_level     <= '0;
         r_time      <= TIME_INIT;
         r_money     <= '0;
         r_lvl_money <= '0;
         r_last      <= 1'b0;
      end else begin
         r_enable_d <= enable;

         if ((r_state == LOAD) && w_load_done) begin
            r_time      <= TIME_INIT;
            r_lvl_money <= '0;
         end

         if (w_tick && (r_time != '0)) begin
            r_time <= r_time - 1'b1;
         end

         // A collect in the expiry cycle still counts toward grading.
         if (w_collect) begin
            r_money     <= w_money_sat;
            r_lvl_money <= w_lvl_sat;
         end

         if ((r_state == DONE) && w_pass) begin
            if (r_level == LAST_LEVEL) begin
               r_last <= 1'b1;
            end else begin
               r_level <= r_level + 1'b1;
            end
         end
      end
   end

   assign romAddr        = w_rom_addr;
   assign objWrEn        = w_wr_en;
   assign objWrIdx       = w_wr_idx;
   assign objWrData      = w_wr_en ? romData : '0;
   assign loading        = (r_state == LOAD);
   assign playing        = w_active;
   assign currentLevel   = r_level;
   assign timeLeft       = r_time;
   assign money          = r_money;
   assign lastLevelEnded = r_last;

   // The loader's busy flag spans exactly the LOAD state.
   logic w_unused_busy;
   assign w_unused_busy = w_load_busy;

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: randomized collects and ROM contents
// scored against a small level/money/timer model of the game rules.
module tb_stage_sequencer;
   import stage_pkg::*;

   localparam int NL  = 2;
   localparam int OC  = 2;
   localparam int FL  = 3;
   localparam int DW  = 9;
   localparam int TL  = 3;
   localparam int TW  = 9;
   localparam int MW  = 16;
   localparam int GB  = 100;
   localparam int GS  = 50;
   localparam int N   = OC * FL;
   localparam int RAW = width_of(NL * N);
   localparam int IW  = width_of(N);
   localparam int LW  = width_of(NL);
   localparam int MMAX = (1 << MW) - 1;
   localparam int OUTW = RAW + 1 + IW + DW + 2 + LW + TW + MW + 3;

   logic           clk = 1'b0;
   logic           resetN = 1'b0;
   logic           enable = 1'b0;
   logic           oneSecPulse = 1'b0;
   logic           collectValid = 1'b0;
   logic [MW-1:0]  collectValue = '0;
   logic [RAW-1:0] romAddr;
   logic [DW-1:0]  romData;
   logic           objWrEn;
   logic [IW-1:0]  objWrIdx;
   logic [DW-1:0]  objWrData;
   logic           loading;
   logic           playing;
   logic [LW-1:0]  currentLevel;
   logic [TW-1:0]  timeLeft;
   logic [MW-1:0]  money;
   logic           stageEnded;
   logic           stageFailed;
   logic           lastLevelEnded;

   logic [DW-1:0]  rom [0:NL*N-1];

   int n_cmp = 0;
   int n_err = 0;
   string scen = "none";

   // Reference model of the game state.
   int m_level;
   int m_money;
   int m_lvl_money;
   int m_time;
   bit m_last;

   stage_sequencer #(
      .NUM_LEVELS    (NL),
      .OBJECTS_COUNT (OC),
      .FIELDS        (FL),
      .DATA_W        (DW),
      .TIME_LIMIT    (TL),
      .TIME_W        (TW),
      .MONEY_W       (MW),
      .GOAL_BASE     (GB),
      .GOAL_STEP     (GS)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .enable         (enable),
      .oneSecPulse    (oneSecPulse),
      .collectValid   (collectValid),
      .collectValue   (collectValue),
      .romAddr        (romAddr),
      .romData        (romData),
      .objWrEn        (objWrEn),
      .objWrIdx       (objWrIdx),
      .objWrData      (objWrData),
      .loading        (loading),
      .playing        (playing),
      .currentLevel   (currentLevel),
      .timeLeft       (timeLeft),
      .money          (money),
      .stageEnded     (stageEnded),
      .stageFailed    (stageFailed),
      .lastLevelEnded (lastLevelEnded)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: data for an address appears one cycle later.
   always @(posedge clk) romData <= rom[romAddr];

   function automatic int sat(input int v);
      return (v > MMAX) ? MMAX : v;
   endfunction

   function automatic logic [OUTW-1:0] reset_vector();
      return {RAW'(0), 1'b0, IW'(0), DW'(0), 1'b0, 1'b0, LW'(0), TW'(TL), MW'(0), 3'b000};
   endfunction

   task automatic model_reset();
      m_level = 0;
      m_money = 0;
      m_lvl_money = 0;
      m_time = TL;
      m_last = 0;
   endtask

   // Enable rising edge, then every LOAD cycle: address, write and loading flag.
   task automatic do_load();
      logic [DW-1:0] exp_data;
      enable = 1'b1;
      for (int c = 0; c <= N; c++) begin
         @(negedge clk);
         n_cmp++;
         if (loading !== 1'b1) begin
            n_err++;
            $display("FAIL %s loading c=%0d: got %b want 1", scen, c, loading);
         end
         if (c < N) begin
            n_cmp++;
            if (romAddr !== RAW'(m_level * N + c)) begin
               n_err++;
               $display("FAIL %s rom_addr c=%0d: got %0d want %0d", scen, c, romAddr, m_level * N + c);
            end
         end
         n_cmp++;
         if (c == 0) begin
            if (objWrEn !== 1'b0) begin
               n_err++;
               $display("FAIL %s early_write: got wr_en %b want 0", scen, objWrEn);
            end
         end else begin
            exp_data = rom[m_level * N + c - 1];
            if ({objWrEn, objWrIdx, objWrData} !== {1'b1, IW'(c - 1), exp_data}) begin
               n_err++;
               $display("FAIL %s write c=%0d: got en=%b idx=%0d data=%0h want en=1 idx=%0d data=%0h",
                        scen, c, objWrEn, objWrIdx, objWrData, c - 1, exp_data);
            end
         end
      end
      @(negedge clk);
      m_time = TL;
      m_lvl_money = 0;
      n_cmp++;
      if ({loading, playing, objWrEn, timeLeft} !== {1'b0, 1'b1, 1'b0, TW'(TL)}) begin
         n_err++;
         $display("FAIL %s after_load: got loading=%b playing=%b wr=%b time=%0d want 0 1 0 %0d",
                  scen, loading, playing, objWrEn, timeLeft, TL);
      end
   endtask

   // One PLAY cycle of stimulus; grading is checked when the model expects expiry.
   task automatic play_cycle(input bit cv, input int val, input bit ps, output bit expired);
      bit pass;
      bit en;
      en = enable;
      collectValid = cv;
      collectValue = MW'(val);
      oneSecPulse  = ps;
      @(negedge clk);
      collectValid = 1'b0;
      collectValue = '0;
      oneSecPulse  = 1'b0;
      expired = 1'b0;
      if (en) begin
         if (cv) begin
            m_money     = sat(m_money + val);
            m_lvl_money = sat(m_lvl_money + val);
         end
         if (ps) begin
            m_time--;
            expired = (m_time == 0);
         end
      end
      n_cmp++;
      if ({timeLeft, money, playing} !== {TW'(m_time), MW'(m_money), en && !expired}) begin
         n_err++;
         $display("FAIL %s play: got time=%0d money=%0d playing=%b want %0d %0d %b",
                  scen, timeLeft, money, playing, m_time, m_money, en && !expired);
      end
      if (expired) begin
         pass = (m_lvl_money >= GB + m_level * GS);
         n_cmp++;
         if ({stageEnded, stageFailed} !== {pass, !pass}) begin
            n_err++;
            $display("FAIL %s grade: got ended=%b failed=%b want %b %b (level money %0d)",
                     scen, stageEnded, stageFailed, pass, !pass, m_lvl_money);
         end
         if (pass) begin
            if (m_level == NL - 1) m_last = 1;
            else m_level++;
         end
         @(negedge clk);
         n_cmp++;
         if ({stageEnded, stageFailed, loading, playing, currentLevel, lastLevelEnded}
             !== {4'b0000, LW'(m_level), m_last}) begin
            n_err++;
            $display("FAIL %s post_grade: got ended=%b failed=%b ld=%b pl=%b level=%0d last=%b want 0 0 0 0 %0d %b",
                     scen, stageEnded, stageFailed, loading, playing, currentLevel, lastLevelEnded,
                     m_level, m_last);
         end
      end
   endtask

   task automatic rearm_and_load();
      enable = 1'b0;
      @(negedge clk);
      do_load();
   endtask

   task automatic apply_reset();
      enable = 1'b0;
      resetN = 1'b0;
      @(negedge clk);
      model_reset();
      n_cmp++;
      if ({romAddr, objWrEn, objWrIdx, objWrData, loading, playing, currentLevel, timeLeft, money,
           stageEnded, stageFailed, lastLevelEnded} !== reset_vector()) begin
         n_err++;
         $display("FAIL %s reset_values: got %0h want %0h", scen,
                  {romAddr, objWrEn, objWrIdx, objWrData, loading, playing, currentLevel, timeLeft,
                   money, stageEnded, stageFailed, lastLevelEnded}, reset_vector());
      end
      resetN = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      scen = "reset";
      apply_reset();
      n_cmp++;
      if ({loading, timeLeft, money} !== {1'b0, TW'(TL), MW'(0)}) begin
         n_err++;
         $display("FAIL %s idle_after_release: got ld=%b time=%0d money=%0d want 0 %0d 0",
                  scen, loading, timeLeft, money, TL);
      end
   endtask

   task automatic test_first_load();
      scen = "first_load";
      do_load();
   endtask

   task automatic test_level0_pass();
      bit ex;
      int a;
      scen = "level0_pass";
      a = $urandom_range(1, 119);
      play_cycle(1, a, 0, ex);
      play_cycle(1, 120 - a, 0, ex);
      for (int i = 0; i < TL; i++) play_cycle(0, 0, 1, ex);
      n_cmp++;
      if (currentLevel !== LW'(1)) begin
         n_err++;
         $display("FAIL %s level: got %0d want 1", scen, currentLevel);
      end
      rearm_and_load();
   endtask

   task automatic test_level1_fail();
      bit ex;
      int a;
      scen = "level1_fail";
      a = $urandom_range(0, 149);
      play_cycle(1, a, 0, ex);
      play_cycle(0, 0, 1, ex);
      play_cycle(1, 149 - a, 0, ex);
      play_cycle(0, 0, 1, ex);
      play_cycle(0, 0, 1, ex);
      n_cmp++;
      if ({currentLevel, money} !== {LW'(1), MW'(269)}) begin
         n_err++;
         $display("FAIL %s keep_state: got level=%0d money=%0d want 1 269", scen, currentLevel, money);
      end
      rearm_and_load();
   endtask

   task automatic test_pause();
      bit ex;
      scen = "pause";
      play_cycle(0, 0, 1, ex);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) play_cycle(1, $urandom_range(1, 200), 1, ex);
      enable = 1'b1;
      play_cycle(0, 0, 0, ex);
   endtask

   task automatic test_same_cycle_expiry();
      bit ex;
      int a;
      scen = "same_cycle";
      play_cycle(0, 0, 1, ex);
      a = $urandom_range(0, 140);
      play_cycle(1, a, 0, ex);
      play_cycle(1, 140 - a, 0, ex);
      play_cycle(1, 10, 1, ex);
      n_cmp++;
      if ({lastLevelEnded, currentLevel} !== {1'b1, LW'(1)}) begin
         n_err++;
         $display("FAIL %s last_level: got last=%b level=%0d want 1 1", scen, lastLevelEnded, currentLevel);
      end
      for (int i = 0; i < 4; i++) begin
         enable = 1'b0;
         @(negedge clk);
         enable = 1'b1;
         @(negedge clk);
         @(negedge clk);
         n_cmp++;
         if ({loading, lastLevelEnded} !== 2'b01) begin
            n_err++;
            $display("FAIL %s ignore_enable i=%0d: got loading=%b last=%b want 0 1",
                     scen, i, loading, lastLevelEnded);
         end
      end
   endtask

   task automatic test_saturation();
      bit ex;
      scen = "saturation";
      apply_reset();
      do_load();
      play_cycle(1, 'hFFF0, 0, ex);
      play_cycle(1, 'h20, 0, ex);
      n_cmp++;
      if (money !== 16'hFFFF) begin
         n_err++;
         $display("FAIL %s clamp: got %0h want ffff", scen, money);
      end
      for (int i = 0; i < TL; i++) play_cycle(0, 0, 1, ex);
   endtask

   task automatic test_reset_mid_load();
      scen = "reset_mid_load";
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (loading !== 1'b1) begin
         n_err++;
         $display("FAIL %s in_load: got %b want 1", scen, loading);
      end
      #1;
      resetN = 1'b0;
      #1;
      n_cmp++;
      if ({romAddr, objWrEn, objWrIdx, objWrData, loading, playing, currentLevel, timeLeft, money,
           stageEnded, stageFailed, lastLevelEnded} !== reset_vector()) begin
         n_err++;
         $display("FAIL %s async_clear: got %0h want %0h", scen,
                  {romAddr, objWrEn, objWrIdx, objWrData, loading, playing, currentLevel, timeLeft,
                   money, stageEnded, stageFailed, lastLevelEnded}, reset_vector());
      end
      enable = 1'b0;
      @(negedge clk);
      resetN = 1'b1;
      model_reset();
      @(negedge clk);
      n_cmp++;
      if ({loading, stageEnded, stageFailed, money} !== {3'b000, MW'(0)}) begin
         n_err++;
         $display("FAIL %s after_release: got ld=%b se=%b sf=%b money=%0d want 0 0 0 0",
                  scen, loading, stageEnded, stageFailed, money);
      end
   endtask

   task automatic test_random_play();
      bit ex;
      scen = "random";
      apply_reset();
      do_load();
      for (int i = 0; i < 80 && !m_last; i++) begin
         enable = ($urandom_range(0, 4) != 0);
         play_cycle($urandom_range(0, 1), $urandom_range(0, 90), ($urandom_range(0, 3) == 0), ex);
         if (ex && !m_last) rearm_and_load();
         else if (!enable) enable = 1'b1;
      end
   endtask

   initial begin
      for (int i = 0; i < NL * N; i++) rom[i] = DW'($urandom);
      model_reset();
      test_reset();
      test_first_load();
      test_level0_pass();
      test_level1_fail();
      test_pause();
      test_same_cycle_expiry();
      test_saturation();
      test_reset_mid_load();
      test_random_play();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
